// File: rtl/mca_dma_arbiter.sv
// mca_dma_arbiter: Micro Channel local-bus arbiter that wins the channel for the card's DMA request.
// Ports: clk14/chreset_l clock and async active-low reset; arb_level/arb_en POS level and enable;
// dreq, tc_l, cmd, arb_grant_l asynchronous bus/DSP inputs; arb_in ARB pin values;
// arb_oe/preempt_oe/burst_oe open-drain pull-down enables; dack_l DMA acknowledge; owned status.
// Optional: define MCA_DMA_BURST_EN to hold ownership across transfers (burst mode).
module mca_dma_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CLKS = 4
) (
  input  logic       clk14,
  input  logic       chreset_l,
  input  logic [3:0] arb_level,
  input  logic       arb_en,
  input  logic       dreq,
  input  logic       tc_l,
  input  logic       cmd,
  input  logic       arb_grant_l,
  input  logic [3:0] arb_in,
  output logic [3:0] arb_oe,
  output logic       preempt_oe,
  output logic       burst_oe,
  output logic       dack_l,
  output logic       owned
);
  typedef enum logic [2:0] {IDLE, REQ, ARB, WAIT_GRANT, OWN, RELEASE} state_t;
  localparam int CW = $clog2(SETTLE_CLKS + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CLKS);
  // synchronizer word is {dreq, tc_l, cmd, arb_grant_l}, reset to their idle levels
  localparam logic [3:0] SYNC_IDLE = 4'b0111;
  logic [3:0] sync_sr [SYNC_STAGES];
  logic [3:0] arb_q, hit, lost_above, arb_next;
  logic [CW-1:0] settle;
  logic dreq_s, tc_s, cmd_s, grant_s, cmd_d, grant_d, lost;
  logic cmd_rise, grant_rise, grant_fall, xfer_rel, release_trig;
  state_t state;
  assign {dreq_s, tc_s, cmd_s, grant_s} = sync_sr[SYNC_STAGES-1];
  assign cmd_rise = cmd_s & ~cmd_d;
  assign grant_rise = grant_s & ~grant_d;
  assign grant_fall = ~grant_s & grant_d;
`ifdef MCA_DMA_BURST_EN
  localparam logic BURST = 1'b1;
  assign xfer_rel = 1'b0;
`else
  localparam logic BURST = 1'b0;
  assign xfer_rel = cmd_rise;
`endif
  // a higher bit we left undriven (level 1) but found pulled low means a higher-priority competitor
  assign hit = arb_level & ~arb_q;
  assign lost_above = {1'b0, hit[3], |hit[3:2], |hit[3:1]};
  assign arb_next = ~arb_level & ~lost_above;
  // preemption shows up as the bus returning to arbitration while we own it
  assign release_trig = ~dreq_s | (cmd_rise & ~tc_s) | xfer_rel | grant_rise;
  always_ff @(posedge clk14 or negedge chreset_l) begin
    if (!chreset_l) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_sr[i] <= SYNC_IDLE;
      arb_q <= 4'hF;
      cmd_d <= 1'b1;
      grant_d <= 1'b1;
      lost <= 1'b0;
      settle <= '0;
      state <= IDLE;
      arb_oe <= '0;
      preempt_oe <= 1'b0;
      burst_oe <= 1'b0;
      dack_l <= 1'b1;
      owned <= 1'b0;
    end else begin
      sync_sr[0] <= {dreq, tc_l, cmd, arb_grant_l};
      for (int i = 1; i < SYNC_STAGES; i++) sync_sr[i] <= sync_sr[i-1];
      arb_q <= arb_in;
      cmd_d <= cmd_s;
      grant_d <= grant_s;
      if (!arb_en) begin
        state <= IDLE;
        arb_oe <= '0;
        preempt_oe <= 1'b0;
        burst_oe <= 1'b0;
        dack_l <= 1'b1;
        owned <= 1'b0;
      end else begin
        case (state)
          IDLE: if (dreq_s) begin
            state <= REQ;
            preempt_oe <= 1'b1;
          end
          REQ: if (grant_rise) begin
            state <= ARB;
            lost <= 1'b0;
            settle <= SETTLE_LOAD;
          end
          ARB: begin
            arb_oe <= arb_next;
            settle <= (arb_next != arb_oe) ? SETTLE_LOAD : (settle != '0) ? settle - 1'b1 : settle;
            if (grant_fall) begin
              state <= WAIT_GRANT;
              lost <= (settle != '0);
            end
          end
          WAIT_GRANT: begin
            arb_oe <= '0;
            if (arb_q == arb_level && !lost) begin
              state <= OWN;
              dack_l <= 1'b0;
              owned <= 1'b1;
              preempt_oe <= 1'b0;
              burst_oe <= BURST;
            end else state <= REQ;
          end
          OWN: if (release_trig) begin
            state <= RELEASE;
            dack_l <= 1'b1;
            owned <= 1'b0;
            burst_oe <= 1'b0;
          end
          RELEASE: if (grant_s) begin
            state <= dreq_s ? REQ : IDLE;
            preempt_oe <= dreq_s;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mca_dma_arbiter.sv
// tb_mca_dma_arbiter: directed and randomized checks of mca_dma_arbiter against a bus-level model.
module tb_mca_dma_arbiter;
  logic clk14 = 1'b0;
  logic chreset_l, arb_en, dreq, tc_l, cmd, arb_grant_l;
  logic [3:0] arb_level, arb_in, arb_oe;
  logic preempt_oe, burst_oe, dack_l, owned;
  logic comp_en = 1'b0;
  logic [3:0] comp_level = 4'hF;
  logic [3:0] comp_oe = 4'h0;
  int checks = 0;
  int failures = 0;

  mca_dma_arbiter dut (
    .clk14(clk14), .chreset_l(chreset_l), .arb_level(arb_level), .arb_en(arb_en),
    .dreq(dreq), .tc_l(tc_l), .cmd(cmd), .arb_grant_l(arb_grant_l), .arb_in(arb_in),
    .arb_oe(arb_oe), .preempt_oe(preempt_oe), .burst_oe(burst_oe), .dack_l(dack_l), .owned(owned)
  );

  always #35 clk14 = ~clk14;

  // wired-AND ARB bus with pull-ups: any agent driving a bit pulls it low
  assign arb_in = ~(arb_oe | comp_oe);

  // second master: drives its zero bits from the top, backs off below the first bit it is beaten on
  function automatic logic [3:0] comp_drive(input logic [3:0] lvl, input logic [3:0] bus);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      if (!lvl[i]) d[i] = 1'b1;
      else if (!bus[i]) break;
    end
    return d;
  endfunction

  always @(posedge clk14) comp_oe <= comp_en ? comp_drive(comp_level, arb_in) : 4'h0;

  // settled drive of our card: full level if we win, else only the bits above the first
  // bit where the competitor's level differs (where we are beaten)
  function automatic logic [3:0] exp_oe(input logic [3:0] own, input logic [3:0] other, input bit present);
    logic [3:0] m;
    int k;
    if (!present || own < other) return ~own;
    k = 3;
    while (own[k] == other[k]) k--;
    m = 4'h0;
    for (int i = 3; i > k; i--) m[i] = 1'b1;
    return ~own & m;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk14);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // one full arbitration cycle: grant low, arbitration phase, grant phase
  task automatic arb_cycle(input int hold, output logic [3:0] oe_seen);
    arb_grant_l = 1'b0;
    step(3);
    arb_grant_l = 1'b1;
    step(hold);
    oe_seen = arb_oe;
    arb_grant_l = 1'b0;
    step(5);
  endtask

  initial begin
    logic [3:0] own, other, seen;
    bit present, win;
    chreset_l = 1'b0;
    arb_en = 1'b1;
    arb_level = 4'h5;
    dreq = 1'b0;
    tc_l = 1'b1;
    cmd = 1'b1;
    arb_grant_l = 1'b1;
    #100;
    step(1);
    chreset_l = 1'b1;
    chk4("rst_arb_oe", arb_oe, 4'h0);
    chk1("rst_preempt", preempt_oe, 1'b0);
    chk1("rst_burst", burst_oe, 1'b0);
    chk1("rst_dack", dack_l, 1'b1);
    chk1("rst_owned", owned, 1'b0);
    dreq = 1'b1;
    step(2);
    chk1("req_preempt_early", preempt_oe, 1'b0);
    step(1);
    chk1("req_preempt_lat", preempt_oe, 1'b1);
    chk1("req_dack", dack_l, 1'b1);
    arb_cycle(10, seen);
    chk4("uncont_arb_oe", seen, 4'b1010);
    chk1("uncont_dack", dack_l, 1'b0);
    chk1("uncont_owned", owned, 1'b1);
    chk1("uncont_preempt", preempt_oe, 1'b0);
    chk4("uncont_oe_clr", arb_oe, 4'h0);
`ifdef MCA_DMA_BURST_EN
    chk1("burst_on", burst_oe, 1'b1);
    for (int t = 0; t < 3; t++) begin
      tc_l = (t == 2) ? 1'b0 : 1'b1;
      cmd = 1'b0;
      step(3);
      cmd = 1'b1;
      step(3);
      chk1("burst_dack", dack_l, (t == 2) ? 1'b1 : 1'b0);
      chk1("burst_oe", burst_oe, (t == 2) ? 1'b0 : 1'b1);
    end
    tc_l = 1'b1;
`else
    chk1("single_burst_off", burst_oe, 1'b0);
    cmd = 1'b0;
    step(3);
    chk1("single_cmd_low", dack_l, 1'b0);
    cmd = 1'b1;
    step(3);
    chk1("single_dack_rel", dack_l, 1'b1);
`endif
    chk1("rel_owned", owned, 1'b0);
    step(3);
    chk1("rel_no_rereq", preempt_oe, 1'b0);
    arb_grant_l = 1'b1;
    step(4);
    chk1("rel_rereq", preempt_oe, 1'b1);
    comp_level = 4'h3;
    comp_en = 1'b1;
    arb_cycle(10, seen);
    comp_en = 1'b0;
    chk4("cont_arb_oe", seen, 4'b1000);
    chk1("cont_dack", dack_l, 1'b1);
    chk1("cont_preempt", preempt_oe, 1'b1);
    chk1("cont_owned", owned, 1'b0);
    arb_en = 1'b0;
    step(1);
    chk1("en_off_preempt", preempt_oe, 1'b0);
    arb_en = 1'b1;
    step(1);
    chk1("en_on_preempt", preempt_oe, 1'b1);
    for (int n = 0; n < 16; n++) begin
      own = 4'($urandom_range(0, 15));
      present = ($urandom_range(0, 3) != 0);
      do other = 4'($urandom_range(0, 15)); while (other == own);
      win = !present || own < other;
      arb_level = own;
      comp_level = other;
      comp_en = present;
      arb_cycle(12, seen);
      comp_en = 1'b0;
      chk4("rnd_arb_oe", seen, exp_oe(own, other, present));
      chk1("rnd_dack", dack_l, !win);
      chk1("rnd_owned", owned, win);
      if (win) begin
        dreq = 1'b0;
        step(4);
        chk1("rnd_drop_dack", dack_l, 1'b1);
        arb_grant_l = 1'b1;
        step(4);
        chk1("rnd_idle_preempt", preempt_oe, 1'b0);
        dreq = 1'b1;
        step(4);
        chk1("rnd_req_preempt", preempt_oe, 1'b1);
      end else chk1("rnd_lose_preempt", preempt_oe, 1'b1);
    end
    arb_level = 4'h5;
    arb_cycle(10, seen);
    chk1("pre_rst_dack", dack_l, 1'b0);
    #10;
    chreset_l = 1'b0;
    #1;
    chk1("arst_dack", dack_l, 1'b1);
    chk4("arst_arb_oe", arb_oe, 4'h0);
    chk1("arst_preempt", preempt_oe, 1'b0);
    chk1("arst_burst", burst_oe, 1'b0);
    chk1("arst_owned", owned, 1'b0);
    #20;
    chreset_l = 1'b1;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
